// File: rtl/spad_pkg.sv
// Shared types and constants for the DPM scratchpad access controller.
package spad_pkg;

    localparam int unsigned SPAD_DEPTH = 16;
    localparam int unsigned SPAD_AW    = 4;
    localparam int unsigned SPAD_DW    = 32;
    localparam int unsigned SPAD_BW    = 4;

    localparam logic [1:0] SPAD_LEN_BYTE = 2'b00;
    localparam logic [1:0] SPAD_LEN_WORD = 2'b01;
    localparam logic [1:0] SPAD_LEN_LONG = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } spad_state_e;

endpackage

// File: rtl/spad_bemask.sv
// Byte-enable mask and write-data alignment for microcode accesses.
// The mask is shifted without wrap, so lanes pushed past byte 3 are dropped.
module spad_bemask
    import spad_pkg::*;
(
    input  logic [1:0]  len_h,
    input  logic [1:0]  bofs_h,
    input  logic [31:0] wdata_h,
    output logic [3:0]  mask_h,
    output logic [31:0] data_h
);

    logic [3:0] base_mask;

    // Base mask by length; the unused 11 encoding is treated as longword.
    always_comb begin
        base_mask = 4'b1111;
        case (len_h)
            SPAD_LEN_BYTE: base_mask = 4'b0001;
            SPAD_LEN_WORD: base_mask = 4'b0011;
            default:       base_mask = 4'b1111;
        endcase
        mask_h = 4'(base_mask << bofs_h);
        data_h = wdata_h << {bofs_h, 3'b000};
    end

endmodule

// File: rtl/spad_ctl.sv
// Scratchpad access controller: arbitrates microcode (U) and service (S)
// ports onto the 16x32 temporary register bank with a starvation guard for S.
// Optional feature: define SPAD_BURST_EN for multi-beat S bursts; without it
// every S request is a single longword beat.
module spad_ctl
    import spad_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
)
(
    input  logic        clk,
    input  logic        reset_l,
    input  logic        u_req_h,
    input  logic        u_we_h,
    input  logic [3:0]  u_addr_h,
    input  logic [1:0]  u_len_h,
    input  logic [1:0]  u_bofs_h,
    input  logic [31:0] u_wdata_h,
    output logic        u_gnt_h,
    input  logic        s_req_h,
    input  logic        s_we_h,
    input  logic [3:0]  s_addr_h,
    input  logic [3:0]  s_cnt_h,
    input  logic [31:0] s_wdata_h,
    output logic        s_ack_h,
    output logic        s_busy_h,
    output logic        s_done_h,
    output logic [3:0]  mspa_h,
    output logic [3:0]  spw_l,
    output logic        mcs_tmp_l,
    output logic [31:0] wbus_h,
    input  logic [31:0] mbus_l,
    output logic [31:0] rdata_h,
    output logic        rvalid_h,
    output logic        rsrc_h
);

    spad_state_e state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        s_we_q, s_we_d;
    logic [3:0]  ptr_q, ptr_d;
`ifdef SPAD_BURST_EN
    logic [3:0]  cnt_q, cnt_d;
`else
    logic [3:0]  unused_s_cnt;
    assign unused_s_cnt = s_cnt_h;
`endif
    logic [3:0]  mspa_q, mspa_d;
    logic [3:0]  spw_q, spw_d;
    logic        mcs_q, mcs_d;
    logic [31:0] wbus_q, wbus_d;
    logic        rd_pend_q, rd_pend_d;
    logic        rd_src_q, rd_src_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        rsrc_q, rsrc_d;

    logic        gnt_u, gnt_s, done_c, s_pend;
    logic [3:0]  u_mask;
    logic [31:0] u_data;

    spad_bemask u_bemask (
        .len_h   (u_len_h),
        .bofs_h  (u_bofs_h),
        .wdata_h (u_wdata_h),
        .mask_h  (u_mask),
        .data_h  (u_data)
    );

    // Arbitration, burst sequencing and next RAM cycle controls.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        s_we_d    = s_we_q;
        ptr_d     = ptr_q;
`ifdef SPAD_BURST_EN
        cnt_d     = cnt_q;
`endif
        mspa_d    = mspa_q;
        spw_d     = 4'b1111;
        mcs_d     = 1'b1;
        wbus_d    = wbus_q;
        rd_pend_d = 1'b0;
        rd_src_d  = rd_src_q;
        gnt_u     = 1'b0;
        gnt_s     = 1'b0;
        done_c    = 1'b0;
        s_pend    = (state_q == ST_BURST);

        if (s_pend && (starve_q >= 4'(STARVE_LIMIT))) begin
            gnt_s = 1'b1;
        end else if (u_req_h) begin
            gnt_u = 1'b1;
        end else if (s_pend) begin
            gnt_s = 1'b1;
        end

        if (gnt_s) begin
            starve_d = 4'd0;
        end else if (s_pend) begin
            starve_d = starve_q + 4'd1;
        end

        if (state_q == ST_IDLE && s_req_h) begin
            state_d  = ST_BURST;
            starve_d = 4'd0;
            s_we_d   = s_we_h;
            ptr_d    = s_addr_h;
`ifdef SPAD_BURST_EN
            cnt_d    = s_cnt_h;
`endif
        end

        if (gnt_u) begin
            mcs_d  = 1'b0;
            mspa_d = u_addr_h;
            if (u_we_h) begin
                spw_d  = ~u_mask;
                wbus_d = u_data;
            end else begin
                rd_pend_d = 1'b1;
                rd_src_d  = 1'b0;
            end
        end

        if (gnt_s) begin
            mcs_d  = 1'b0;
            mspa_d = ptr_q;
            if (s_we_q) begin
                spw_d  = 4'b0000;
                wbus_d = s_wdata_h;
            end else begin
                rd_pend_d = 1'b1;
                rd_src_d  = 1'b1;
            end
`ifdef SPAD_BURST_EN
            ptr_d = ptr_q + 4'd1;
            if (cnt_q == 4'd0) begin
                state_d = ST_IDLE;
                done_c  = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
`else
            state_d = ST_IDLE;
            done_c  = 1'b1;
`endif
        end
    end

    // Read data capture at the end of the RAM cycle.
    always_comb begin
        rdata_d  = rdata_q;
        rsrc_d   = rsrc_q;
        rvalid_d = rd_pend_q;
        if (rd_pend_q) begin
            rdata_d = ~mbus_l;
            rsrc_d  = rd_src_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q   <= ST_IDLE;
            starve_q  <= 4'd0;
            s_we_q    <= 1'b0;
            ptr_q     <= 4'd0;
`ifdef SPAD_BURST_EN
            cnt_q     <= 4'd0;
`endif
            mspa_q    <= 4'd0;
            spw_q     <= 4'b1111;
            mcs_q     <= 1'b1;
            wbus_q    <= 32'd0;
            rd_pend_q <= 1'b0;
            rd_src_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rvalid_q  <= 1'b0;
            rsrc_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            s_we_q    <= s_we_d;
            ptr_q     <= ptr_d;
`ifdef SPAD_BURST_EN
            cnt_q     <= cnt_d;
`endif
            mspa_q    <= mspa_d;
            spw_q     <= spw_d;
            mcs_q     <= mcs_d;
            wbus_q    <= wbus_d;
            rd_pend_q <= rd_pend_d;
            rd_src_q  <= rd_src_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            rsrc_q    <= rsrc_d;
        end
    end

    assign u_gnt_h   = gnt_u;
    assign s_ack_h   = gnt_s;
    assign s_done_h  = done_c;
    assign s_busy_h  = (state_q == ST_BURST);
    assign mspa_h    = mspa_q;
    assign spw_l     = spw_q;
    assign mcs_tmp_l = mcs_q;
    assign wbus_h    = wbus_q;
    assign rdata_h   = rdata_q;
    assign rvalid_h  = rvalid_q;
    assign rsrc_h    = rsrc_q;

endmodule

// File: tb/tb_spad_ctl.sv
// Scoreboard bench for spad_ctl: stimulus pushes expected RAM cycles and
// read returns; a negedge monitor pops and compares them as they appear.
`timescale 1ns/1ps
module tb_spad_ctl;
    import spad_pkg::*;

    localparam int unsigned LIMIT = 4;
`ifdef SPAD_BURST_EN
    localparam int NB_BURST = 4;
    localparam int NB_STARVE = 3;
`else
    localparam int NB_BURST = 1;
    localparam int NB_STARVE = 1;
`endif

    logic        clk, reset_l;
    logic        u_req_h, u_we_h, u_gnt_h;
    logic [3:0]  u_addr_h;
    logic [1:0]  u_len_h, u_bofs_h;
    logic [31:0] u_wdata_h;
    logic        s_req_h, s_we_h, s_ack_h, s_busy_h, s_done_h;
    logic [3:0]  s_addr_h, s_cnt_h;
    logic [31:0] s_wdata_h;
    logic [3:0]  mspa_h, spw_l;
    logic        mcs_tmp_l;
    logic [31:0] wbus_h, mbus_l, rdata_h;
    logic        rvalid_h, rsrc_h;

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  spw;
        logic [31:0] wbus;
        logic        chk_wbus;
    } ram_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        src;
    } rd_exp_t;

    ram_exp_t ram_q[$];
    rd_exp_t  rd_q[$];
    int n_cmp = 0;
    int n_err = 0;

    spad_ctl #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_l(reset_l),
        .u_req_h(u_req_h), .u_we_h(u_we_h), .u_addr_h(u_addr_h),
        .u_len_h(u_len_h), .u_bofs_h(u_bofs_h), .u_wdata_h(u_wdata_h),
        .u_gnt_h(u_gnt_h),
        .s_req_h(s_req_h), .s_we_h(s_we_h), .s_addr_h(s_addr_h),
        .s_cnt_h(s_cnt_h), .s_wdata_h(s_wdata_h),
        .s_ack_h(s_ack_h), .s_busy_h(s_busy_h), .s_done_h(s_done_h),
        .mspa_h(mspa_h), .spw_l(spw_l), .mcs_tmp_l(mcs_tmp_l),
        .wbus_h(wbus_h), .mbus_l(mbus_l),
        .rdata_h(rdata_h), .rvalid_h(rvalid_h), .rsrc_h(rsrc_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ram(input logic [3:0] a, input logic [3:0] spw,
                            input logic [31:0] d, input logic cw);
        ram_exp_t e;
        e.addr = a; e.spw = spw; e.wbus = d; e.chk_wbus = cw;
        ram_q.push_back(e);
    endtask

    task automatic push_rd(input logic [31:0] d, input logic src);
        rd_exp_t e;
        e.data = d; e.src = src;
        rd_q.push_back(e);
    endtask

    // Monitor: every RAM select and every read return must match the queue head.
    always @(negedge clk) begin
        ram_exp_t re;
        rd_exp_t  de;
        if (reset_l === 1'b1 && mcs_tmp_l !== 1'b1) begin
            if (ram_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_sel: got mspa=%0d spw=%b expected no select at %0t",
                         mspa_h, spw_l, $time);
            end else begin
                re = ram_q.pop_front();
                chk("ram_addr", 32'(mspa_h), 32'(re.addr));
                chk("ram_spw", 32'(spw_l), 32'(re.spw));
                if (re.chk_wbus) chk("ram_wbus", wbus_h, re.wbus);
            end
        end
        if (reset_l === 1'b1 && rvalid_h !== 1'b0) begin
            if (rd_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_rvalid: got rdata=%h expected no rvalid at %0t",
                         rdata_h, $time);
            end else begin
                de = rd_q.pop_front();
                chk("rdata", rdata_h, de.data);
                chk("rsrc", 32'(rsrc_h), 32'(de.src));
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int beat, acks, dones, done_at, first_ack, last_ack, sb;
        logic exp_s;

        reset_l = 1'b0;
        u_req_h = 0; u_we_h = 0; u_addr_h = 0; u_len_h = 0; u_bofs_h = 0; u_wdata_h = 0;
        s_req_h = 0; s_we_h = 0; s_addr_h = 0; s_cnt_h = 0; s_wdata_h = 0;
        mbus_l = 32'hFFFF_FFFF;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_mspa", 32'(mspa_h), 0);
        chk("rst_spw", 32'(spw_l), 32'hF);
        chk("rst_mcs", 32'(mcs_tmp_l), 1);
        chk("rst_wbus", wbus_h, 0);
        chk("rst_rdata", rdata_h, 0);
        chk("rst_rvalid", 32'(rvalid_h), 0);
        chk("rst_rsrc", 32'(rsrc_h), 0);
        chk("rst_ugnt", 32'(u_gnt_h), 0);
        chk("rst_sack", 32'(s_ack_h), 0);
        chk("rst_busy", 32'(s_busy_h), 0);
        chk("rst_done", 32'(s_done_h), 0);
        cyc();
        reset_l = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_mcs", 32'(mcs_tmp_l), 1);
        chk("idle_busy", 32'(s_busy_h), 0);

        // U word write at bofs 1, then read-back with timing check.
        cyc();
        u_req_h = 1; u_we_h = 1; u_addr_h = 5; u_len_h = SPAD_LEN_WORD; u_bofs_h = 1;
        u_wdata_h = 32'h0000_ABCD;
        push_ram(4'd5, 4'b1001, 32'h00AB_CD00, 1'b1);
        @(negedge clk);
        chk("u_wr_gnt", 32'(u_gnt_h), 1);
        cyc();
        u_we_h = 0; mbus_l = ~32'h00AB_CD00;
        push_ram(4'd5, 4'b1111, 32'h0, 1'b0);
        push_rd(32'h00AB_CD00, 1'b0);
        @(negedge clk);
        chk("u_rd_gnt", 32'(u_gnt_h), 1);
        cyc();
        u_req_h = 0;
        @(negedge clk);
        chk("rd_n1_rvalid", 32'(rvalid_h), 0);
        chk("rd_n1_mcs", 32'(mcs_tmp_l), 0);
        cyc();
        @(negedge clk);
        chk("rd_n2_rvalid", 32'(rvalid_h), 1);

        // Back-to-back U writes: mask edge cases.
        cyc();
        u_req_h = 1; u_we_h = 1; u_addr_h = 2; u_len_h = SPAD_LEN_BYTE; u_bofs_h = 3;
        u_wdata_h = 32'h0000_005A;
        push_ram(4'd2, 4'b0111, 32'h5A00_0000, 1'b1);
        cyc();
        u_addr_h = 3; u_len_h = SPAD_LEN_WORD; u_bofs_h = 3; u_wdata_h = 32'h0000_1234;
        push_ram(4'd3, 4'b0111, 32'h3400_0000, 1'b1);
        cyc();
        u_addr_h = 7; u_len_h = 2'b11; u_bofs_h = 0; u_wdata_h = 32'hDEAD_BEEF;
        push_ram(4'd7, 4'b0000, 32'hDEAD_BEEF, 1'b1);
        cyc();
        u_addr_h = 8; u_len_h = SPAD_LEN_LONG; u_bofs_h = 2; u_wdata_h = 32'h1122_3344;
        push_ram(4'd8, 4'b0011, 32'h3344_0000, 1'b1);
        cyc();
        u_req_h = 0;
        repeat (3) cyc();

        // S write burst from addr 14, no U traffic.
        s_req_h = 1; s_we_h = 1; s_addr_h = 14; s_cnt_h = 3; s_wdata_h = 32'hB000_0000;
        for (int i = 0; i < NB_BURST; i++)
            push_ram(4'(14 + i), 4'b0000, 32'hB000_0000 | 32'(i), 1'b1);
        cyc();
        s_req_h = 0;
        beat = 0; acks = 0; dones = 0; done_at = -1; first_ack = -1; last_ack = -1;
        for (int c = 0; c < 20 && beat < NB_BURST; c++) begin
            logic acked;
            @(negedge clk);
            acked = s_ack_h;
            if (acked) begin
                acks++;
                if (first_ack < 0) first_ack = c;
                last_ack = c;
            end
            if (s_done_h) begin
                dones++;
                done_at = acks;
            end
            cyc();
            if (acked) beat++;
            s_wdata_h = 32'hB000_0000 | 32'(beat);
        end
        chk("burst_acks", 32'(acks), 32'(NB_BURST));
        chk("burst_first_ack", 32'(first_ack), 0);
        chk("burst_last_ack", 32'(last_ack), 32'(NB_BURST - 1));
        chk("burst_dones", 32'(dones), 1);
        chk("burst_done_at", 32'(done_at), 32'(NB_BURST));
        @(negedge clk);
        chk("burst_end_busy", 32'(s_busy_h), 0);
        repeat (3) cyc();

        // Starvation guard: U held high, S gets every (LIMIT+1)th cycle.
        u_req_h = 1; u_we_h = 1; u_addr_h = 3; u_len_h = SPAD_LEN_LONG; u_bofs_h = 0;
        u_wdata_h = 32'h3333_3333;
        s_req_h = 1; s_we_h = 1; s_addr_h = 8; s_cnt_h = 2; s_wdata_h = 32'hC0DE_0000;
        sb = 0;
        for (int j = 0; j <= 5 * NB_STARVE + 1; j++) begin
            exp_s = (j > 0) && (j % 5 == 0) && (sb < NB_STARVE);
            if (exp_s) push_ram(4'(8 + sb), 4'b0000, 32'hC0DE_0000 | 32'(sb), 1'b1);
            else       push_ram(4'd3, 4'b0000, 32'h3333_3333, 1'b1);
            @(negedge clk);
            chk("starve_ack", 32'(s_ack_h), 32'(exp_s));
            chk("starve_ugnt", 32'(u_gnt_h), 32'(!exp_s));
            chk("starve_done", 32'(s_done_h), 32'(exp_s && (sb == NB_STARVE - 1)));
            cyc();
            s_req_h = 0;
            if (exp_s) begin
                sb++;
                s_wdata_h = 32'hC0DE_0000 | 32'(sb);
            end
        end
        u_req_h = 0;
        repeat (3) cyc();

        // Reset while S work is still outstanding.
`ifdef SPAD_BURST_EN
        s_req_h = 1; s_we_h = 1; s_addr_h = 0; s_cnt_h = 5; s_wdata_h = 32'hF000_0000;
        push_ram(4'd0, 4'b0000, 32'hF000_0000, 1'b1);
        cyc();
        s_req_h = 0;
        @(negedge clk);
        chk("mid_ack1", 32'(s_ack_h), 1);
        cyc();
        s_wdata_h = 32'hF000_0001;
        @(negedge clk);
        chk("mid_ack2", 32'(s_ack_h), 1);
        chk("mid_busy", 32'(s_busy_h), 1);
        cyc();
        reset_l = 1'b0;
`else
        u_req_h = 1; u_we_h = 1; u_addr_h = 3; u_len_h = SPAD_LEN_LONG; u_bofs_h = 0;
        u_wdata_h = 32'h4444_4444;
        s_req_h = 1; s_we_h = 1; s_addr_h = 0; s_wdata_h = 32'hF000_0000;
        push_ram(4'd3, 4'b0000, 32'h4444_4444, 1'b1);
        cyc();
        s_req_h = 0;
        @(negedge clk);
        chk("mid_ack", 32'(s_ack_h), 0);
        chk("mid_busy", 32'(s_busy_h), 1);
        cyc();
        reset_l = 1'b0;
        u_req_h = 0;
`endif
        @(negedge clk);
        chk("rst_mid_busy", 32'(s_busy_h), 0);
        chk("rst_mid_done", 32'(s_done_h), 0);
        chk("rst_mid_mcs", 32'(mcs_tmp_l), 1);
        repeat (2) cyc();
        reset_l = 1'b1;
        dones = 0; acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (s_done_h) dones++;
            if (s_ack_h) acks++;
        end
        chk("post_rst_dones", 32'(dones), 0);
        chk("post_rst_acks", 32'(acks), 0);

        chk("ram_q_left", 32'(ram_q.size()), 0);
        chk("rd_q_left", 32'(rd_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spad_ctl.md
# spad_ctl

Scratchpad access controller for the DPM temporary register bank (16 × 32-bit, byte-writable, active-low read data). It arbitrates between the microcode port (U) and a service port (S) used for register save/restore bursts. It generates the registered RAM controls `mspa_h`, `spw_l`, `mcs_tmp_l` and `wbus_h`, and captures the inverted `mbus_l` read data. U has priority, and a starvation guard bounds how long S can wait.

## Interface
- `STARVE_LIMIT`, 4: consecutive denied S cycles before S is forced through (1..15).
- `clk` in 1: system clock, rising edge.
- `reset_l` in 1: asynchronous, active-low reset.
- `u_req_h` in 1: microcode access request.
- `u_we_h` in 1: 1 = write, 0 = read.
- `u_addr_h` in 4: register address.
- `u_len_h` in 2: 00 byte, 01 word, 10/11 longword.
- `u_bofs_h` in 2: byte offset within the longword.
- `u_wdata_h` in 32: write data, right-justified.
- `u_gnt_h` out 1: U request accepted at this edge (combinational).
- `s_req_h` in 1: service request; sampled only in IDLE.
- `s_we_h` in 1: burst direction.
- `s_addr_h` in 4: burst start address.
- `s_cnt_h` in 4: beats minus 1.
- `s_wdata_h` in 32: current beat data; advances after `s_ack_h`.
- `s_ack_h` out 1: S beat accepted at this edge.
- `s_busy_h` out 1: S burst active.
- `s_done_h` out 1: one-cycle pulse in the cycle the last beat is accepted.
- `mspa_h` out 4: RAM address.
- `spw_l` out 4: per-byte write enables, active low.
- `mcs_tmp_l` out 1: RAM chip select, active low.
- `wbus_h` out 32: RAM write data.
- `mbus_l` in 32: RAM read data, active low.
- `rdata_h` out 32: captured read data, true polarity (`~mbus_l`).
- `rvalid_h` out 1: `rdata_h` valid this cycle.
- `rsrc_h` out 1: source of `rdata_h`; 0 = U, 1 = S.

## Operation
- **States:**
  - IDLE → BURST when `s_req_h`=1 in IDLE. Latch `s_we_h`, `s_addr_h` and `s_cnt_h` into the pointer and beat counter, and assert `s_busy_h`.
  - BURST → IDLE on acceptance of the beat whose counter is 0.
- **Arbitration, per cycle:**
  - If the starvation counter has reached `STARVE_LIMIT` with BURST pending, grant S. `u_gnt_h`=0 even when `u_req_h`=1.
  - Otherwise, if `u_req_h`=1, grant U.
  - Otherwise, if in BURST, grant S.
  - The starvation counter increments on each cycle S is pending and denied. It clears on any S grant and on entering BURST.
- **U access mask and data:**
  - Base mask: byte 0001, word 0011, long 1111.
  - Mask = (base << `u_bofs_h`) truncated to 4 bits; there is no wrap. Example: word at offset 3 writes byte 3 only.
  - Write data = `u_wdata_h` << (8 × `u_bofs_h`), truncated to 32 bits.
- **S beats:**
  - Always longword, mask 1111.
  - Address pointer increments modulo 16, so 15 wraps to 0.
  - Beat counter decrements per accepted beat.
- **Granted access, driven in the next cycle:**
  - `mcs_tmp_l`=0 and `mspa_h` = granted address.
  - Write: `spw_l` = ~mask and `wbus_h` = data.
  - Read: `spw_l`=1111 and `wbus_h` holds its previous value.
  - With no grant: `mcs_tmp_l`=1 and `spw_l`=1111.
- **Reads:** `rdata_h` = ~`mbus_l` is captured at the end of the RAM cycle. `rvalid_h` and `rsrc_h` are asserted the following cycle.
- **Reset values:**
  - `mspa_h`=0, `spw_l`=1111, `mcs_tmp_l`=1, `wbus_h`=0.
  - `rdata_h`=0, `rvalid_h`=0, `rsrc_h`=0.
  - `u_gnt_h`, `s_ack_h`, `s_busy_h` and `s_done_h` all 0.
  - State IDLE, counters 0.
- **Reset mid-burst:** the remaining beats are discarded and `s_done_h` does not pulse.
- **Requests while busy:** `s_req_h` is ignored while `s_busy_h`=1. `u_len_h`=11 behaves as longword.

## Timing
- Request and grant are in cycle N. The RAM access is driven in N+1, read data is captured at the end of N+1, and `rvalid_h` is high in N+2.
- Back-to-back grants give one RAM access per cycle.
- A full-speed 16-beat burst with no U traffic takes cycles N..N+15 for acks; `s_done_h` is at N+15.
- Under continuous U traffic, S still receives one grant every `STARVE_LIMIT`+1 cycles.

## Configuration
- `SPAD_BURST_EN` defined: multi-beat bursts as described above.
- `SPAD_BURST_EN` undefined:
  - `s_cnt_h` is ignored and every S request is a single beat.
  - `s_done_h` coincides with `s_ack_h`.
  - The beat counter and pointer increment logic are removed.
  - Arbitration and the starvation guard are unchanged.

## Structure
- Package `spad_pkg`:
  - Length encodings `SPAD_LEN_BYTE`, `SPAD_LEN_WORD` and `SPAD_LEN_LONG`.
  - State enum (IDLE, BURST).
  - Constant `SPAD_DEPTH`=16.
- Sub-module `spad_bemask`: combinational mask and data-shift generator (len, bofs, wdata → mask, shifted data).

## Test plan
- Reset with `reset_l`=0 → all outputs at their reset values; release → still idle with `mcs_tmp_l`=1.
- U write, addr 5, word, bofs 1, data 0x0000ABCD → next cycle `spw_l`=1001 and `wbus_h`=0x00ABCD00. A subsequent read of addr 5 with `mbus_l`=~0x00ABCD00 gives `rdata_h`=0x00ABCD00 and `rsrc_h`=0, two cycles after the read grant.
- S write burst, addr 14, cnt 3, with no U traffic → `mspa_h` sequence 14, 15, 0, 1; four acks; `s_done_h` on the 4th ack.
- `u_req_h` held high during an S burst with `STARVE_LIMIT`=4 → S ack every 5th cycle with `u_gnt_h`=0 in that cycle.
- `reset_l` asserted after the 2nd beat of a 6-beat burst → `s_busy_h`=0 immediately, no `s_done_h`, and no further RAM selects.
- Byte write at bofs 3 and word write at bofs 3 → `spw_l`=0111 for both.
